wb_port_scheduler: RTL and testbench

//  Owns the single register-file write port shared by the EX (fixed-latency multicycle) pipe,
//  the MEM stage and the ALU. Tracks future EX writeback slots in a reservation shift register,

---
 rtl/wb_port_scheduler.sv | 102 ++++++++++
 tb/tb_wb_port_scheduler.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_scheduler.sv
// ============================================================================
// Module  : wb_port_scheduler
// Purpose : Arbitrates the single register-file write port between EX, MEM, ALU
// Revision: 1.0
// ============================================================================
`default_nettype none

module wb_port_scheduler #(
  parameter int REGISTER_WIDTH = 5,
  parameter int EX_LATENCY     = 5,
  parameter int STARVE_LIMIT   = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      flush_i,
  input  logic                      ex_issue_i,
  output logic                      ex_issue_allowed_o,
  input  logic                      ex_wb_req_i,
  input  logic [REGISTER_WIDTH-1:0] ex_wb_rd_i,
  input  logic                      mem_wb_req_i,
  input  logic [REGISTER_WIDTH-1:0] mem_wb_rd_i,
  input  logic                      alu_wb_req_i,
  input  logic [REGISTER_WIDTH-1:0] alu_wb_rd_i,
  output logic                      ex_allowed_wb_o,
  output logic                      mem_allowed_wb_o,
  output logic                      alu_allowed_wb_o,
  output logic [1:0]                wb_sel_o,
  output logic                      wb_en_o,
  output logic [REGISTER_WIDTH-1:0] wb_rd_o,
  output logic                      wb_is_next_cycle_o,
  output logic                      resv_err_o
);

  localparam int                CNT_W      = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0]  STARVE_MAX = CNT_W'(STARVE_LIMIT);

  localparam logic [1:0] SEL_NONE = 2'd0;
  localparam logic [1:0] SEL_ALU  = 2'd1;
  localparam logic [1:0] SEL_MEM  = 2'd2;
  localparam logic [1:0] SEL_EX   = 2'd3;

  logic [EX_LATENCY-1:0] resv_q;
  logic [CNT_W-1:0]      starve_cnt_q;
  logic                  resv_err_q;
  logic                  issue_acc;

  assign ex_issue_allowed_o = (starve_cnt_q != STARVE_MAX);
  assign issue_acc          = ex_issue_i & ex_issue_allowed_o;
  assign wb_is_next_cycle_o = resv_q[1];
  assign resv_err_o         = resv_err_q;

  // EX owns its pre-reserved slot outright, so it is never refused.
  assign ex_allowed_wb_o  = ex_wb_req_i;
  assign mem_allowed_wb_o = mem_wb_req_i & ~ex_wb_req_i;
  assign alu_allowed_wb_o = alu_wb_req_i & ~ex_wb_req_i & ~mem_wb_req_i;

  always_comb begin
    wb_sel_o = SEL_NONE;
    wb_rd_o  = '0;
    if (ex_allowed_wb_o) begin
      wb_sel_o = SEL_EX;
      wb_rd_o  = ex_wb_rd_i;
    end else if (mem_allowed_wb_o) begin
      wb_sel_o = SEL_MEM;
      wb_rd_o  = mem_wb_rd_i;
    end else if (alu_allowed_wb_o) begin
      wb_sel_o = SEL_ALU;
      wb_rd_o  = alu_wb_rd_i;
    end
  end

  // A write to x0 still consumes the port slot but never reaches the file.
  assign wb_en_o = (wb_sel_o != SEL_NONE) && (wb_rd_o != '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      resv_q       <= '0;
      starve_cnt_q <= '0;
      resv_err_q   <= 1'b0;
    end else begin
      if (ex_wb_req_i != resv_q[0]) begin
        resv_err_q <= 1'b1;
      end
      if (flush_i) begin
        resv_q       <= '0;
        starve_cnt_q <= '0;
      end else begin
        resv_q <= {issue_acc, resv_q[EX_LATENCY-1:1]};
        if (mem_wb_req_i && !mem_allowed_wb_o) begin
          if (starve_cnt_q != STARVE_MAX) begin
            starve_cnt_q <= starve_cnt_q + 1'b1;
          end
        end else begin
          starve_cnt_q <= '0;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wb_port_scheduler.sv
// ============================================================================
// Module  : tb_wb_port_scheduler
// Purpose : Directed and randomized checks of wb_port_scheduler against a model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_wb_port_scheduler;

  localparam int RW  = 5;
  localparam int LAT = 5;
  localparam int LIM = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0, ex_issue = 1'b0, ex_req = 1'b0, mem_req = 1'b0, alu_req = 1'b0;
  logic [RW-1:0] ex_rd = '0, mem_rd = '0, alu_rd = '0;

  logic issue_allowed, ex_g, mem_g, alu_g, wb_en, wb_next, resv_err;
  logic [1:0] wb_sel;
  logic [RW-1:0] wb_rd;

  wb_port_scheduler #(.REGISTER_WIDTH(RW), .EX_LATENCY(LAT), .STARVE_LIMIT(LIM)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .ex_issue_i(ex_issue), .ex_issue_allowed_o(issue_allowed),
    .ex_wb_req_i(ex_req), .ex_wb_rd_i(ex_rd),
    .mem_wb_req_i(mem_req), .mem_wb_rd_i(mem_rd),
    .alu_wb_req_i(alu_req), .alu_wb_rd_i(alu_rd),
    .ex_allowed_wb_o(ex_g), .mem_allowed_wb_o(mem_g), .alu_allowed_wb_o(alu_g),
    .wb_sel_o(wb_sel), .wb_en_o(wb_en), .wb_rd_o(wb_rd),
    .wb_is_next_cycle_o(wb_next), .resv_err_o(resv_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: absolute cycle numbers at which EX writebacks are due.
  int cycle = 0;
  int due[$];
  int starve = 0;
  bit err_m = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  function automatic bit slot_at(input int c);
    foreach (due[i]) if (due[i] == c) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    due.delete();
    starve = 0;
    err_m  = 1'b0;
    cycle  = 0;
  endtask

  task automatic check_outputs();
    bit e, m, a;
    logic [1:0] sel;
    logic [RW-1:0] rd;
    e = ex_req;
    m = mem_req && !ex_req;
    a = alu_req && !ex_req && !mem_req;
    sel = e ? 2'd3 : m ? 2'd2 : a ? 2'd1 : 2'd0;
    rd  = e ? ex_rd : m ? mem_rd : a ? alu_rd : '0;
    check("issue_allowed", issue_allowed, (starve != LIM));
    check("ex_grant", ex_g, e);
    check("mem_grant", mem_g, m);
    check("alu_grant", alu_g, a);
    check("wb_sel", wb_sel, sel);
    check("wb_rd", wb_rd, rd);
    check("wb_en", wb_en, (sel != 0) && (rd != 0));
    check("wb_next", wb_next, slot_at(cycle + 1));
    check("resv_err", resv_err, err_m);
  endtask

  task automatic apply(input bit iss, input bit fl, input bit er, input logic [RW-1:0] erd,
                       input bit mr, input logic [RW-1:0] mrd,
                       input bit ar, input logic [RW-1:0] ard);
    ex_issue = iss; flush = fl; ex_req = er; ex_rd = erd;
    mem_req = mr; mem_rd = mrd; alu_req = ar; alu_rd = ard;
    #2;
    check_outputs();
  endtask

  task automatic tick();
    int keep[$];
    bit allowed;
    allowed = (starve != LIM);
    @(posedge clk);
    if (ex_req != slot_at(cycle)) err_m = 1'b1;
    foreach (due[i]) if (due[i] > cycle) keep.push_back(due[i]);
    due = keep;
    if (flush) begin
      due.delete();
      starve = 0;
    end else begin
      if (ex_issue && allowed) due.push_back(cycle + LAT);
      if (mem_req && ex_req) starve = (starve < LIM) ? starve + 1 : LIM;
      else starve = 0;
    end
    cycle++;
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      apply(0, 0, slot_at(cycle), RW'($urandom), 0, '0, 0, '0);
      tick();
    end
  endtask

  initial begin
    int blocked_at, granted_at, first_deny;
    model_reset();

    // Reset values
    #2;
    check_outputs();
    check("rst_sel", wb_sel, 0);
    check("rst_issue_allowed", issue_allowed, 1);
    check("rst_err", resv_err, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single EX issue, then contested writeback
    apply(1, 0, 0, '0, 0, '0, 0, '0); tick();
    idle(3);
    apply(0, 0, 0, '0, 0, '0, 0, '0);
    check("t4_wb_next", wb_next, 1);
    tick();
    apply(0, 0, 1, 5'd3, 1, 5'd7, 1, 5'd9);
    check("t5_ex_grant", ex_g, 1);
    check("t5_sel", wb_sel, 3);
    check("t5_mem_denied", mem_g, 0);
    tick();

    // MEM beats ALU; ALU to x0 does not write
    apply(0, 0, 0, '0, 1, 5'd7, 1, 5'd4);
    check("mem_win_rd", wb_rd, 7);
    check("mem_win_en", wb_en, 1);
    tick();
    apply(0, 0, 0, '0, 0, '0, 1, 5'd0);
    check("alu_x0_grant", alu_g, 1);
    check("alu_x0_en", wb_en, 0);
    tick();

    // Continuous EX issue against a waiting load
    blocked_at = -1; granted_at = -1; first_deny = -1;
    for (int i = 0; i < 40; i++) begin
      apply(1, 0, slot_at(cycle), RW'($urandom_range(1, 31)), 1, 5'd7, 0, '0);
      if (first_deny < 0 && !mem_g) first_deny = cycle;
      if (blocked_at < 0 && !issue_allowed) blocked_at = cycle;
      if (blocked_at >= 0 && granted_at < 0 && mem_g) granted_at = cycle;
      tick();
      if (granted_at >= 0) break;
    end
    apply(0, 0, slot_at(cycle), '0, 0, '0, 0, '0);
    check("starve_blocks_after_limit", blocked_at - first_deny, LIM);
    check("mem_granted_in_time", (granted_at >= 0) && (granted_at - blocked_at <= LAT), 1);
    check("issue_reopens", issue_allowed, 1);
    tick();
    idle(LAT + 1);

    // Flush discards an in-flight reservation
    apply(1, 0, 0, '0, 0, '0, 0, '0); tick();
    idle(1);
    apply(0, 1, 0, '0, 0, '0, 0, '0); tick();
    for (int i = 0; i < LAT; i++) begin
      apply(0, 0, 0, '0, 0, '0, 0, '0);
      check("flush_no_next", wb_next, 0);
      tick();
    end

    // Randomized traffic with one asynchronous reset in the middle
    for (int i = 0; i < 300; i++) begin
      if (i == 150) begin
        rst_n = 1'b0;
        ex_issue = 0; flush = 0; ex_req = 0; mem_req = 0; alu_req = 0;
        #2;
        model_reset();
        check_outputs();
        @(posedge clk); #1;
        rst_n = 1'b1;
      end
      apply(($urandom_range(0, 1) == 1), ($urandom_range(0, 31) == 0), slot_at(cycle),
            RW'($urandom), ($urandom_range(0, 9) < 4), RW'($urandom),
            ($urandom_range(0, 1) == 1), RW'($urandom));
      tick();
    end
    idle(LAT + 1);

    // Unreserved EX request sets the sticky error
    apply(0, 0, 1, 5'd2, 0, '0, 0, '0); tick();
    apply(0, 0, 0, '0, 0, '0, 0, '0);
    check("err_set", resv_err, 1);
    tick();
    idle(3);
    check("err_sticky", resv_err, 1);
    rst_n = 1'b0;
    #2;
    model_reset();
    check("err_cleared_by_reset", resv_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
